// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencer stepping a shared ALU and unified memory through a MIPS-subset instruction.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD,
    WB_MEM, MEM_WR, BRANCH, JUMP, JAL, JR, ILLEGAL
  } state_t;
  state_t cur, nxt, dispatch;
  logic [3:0] r_op, i_op;
  logic pe, iw, mr, mw, rw;
  always_comb begin
    r_op = 4'b0000;
    case (funct)
      6'd33: r_op = 4'b0101;
      6'd35: r_op = 4'b0110;
      6'd36: r_op = 4'b0001;
      6'd37: r_op = 4'b0011;
      6'd38: r_op = 4'b0010;
      6'd43: r_op = 4'b1000;
      6'd0:  r_op = 4'b1010;
      6'd2:  r_op = 4'b1011;
      default: r_op = 4'b0000;
    endcase
  end
  always_comb begin
    i_op = 4'b0000;
    case (opcode)
      6'd9:  i_op = 4'b0101;
      6'd12: i_op = 4'b0001;
      6'd13: i_op = 4'b0011;
      6'd11: i_op = 4'b1000;
      6'd15: i_op = 4'b1100;
      default: i_op = 4'b0000;
    endcase
  end
  // every supported ALU code is nonzero, so a zero lookup marks an unsupported encoding
  assign dispatch = opcode == 6'd0 ? (funct == 6'd8 ? JR : r_op != 4'b0000 ? EXEC_R : ILLEGAL) :
                    i_op != 4'b0000 ? EXEC_I :
                    (opcode == 6'd35 || opcode == 6'd43) ? MEM_ADDR :
                    (opcode == 6'd4 || opcode == 6'd5) ? BRANCH :
                    opcode == 6'd2 ? JUMP :
                    opcode == 6'd3 ? JAL : ILLEGAL;
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE:   nxt = dispatch;
      EXEC_R:   nxt = WB_R;
      EXEC_I:   nxt = WB_I;
      MEM_ADDR: nxt = opcode == 6'd35 ? MEM_RD : MEM_WR;
      MEM_RD:   nxt = mem_ready ? WB_MEM : MEM_RD;
      MEM_WR:   nxt = mem_ready ? FETCH : MEM_WR;
      ILLEGAL:  nxt = ILLEGAL;
      default:  nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cur <= FETCH;
    else cur <= nxt;
  always_comb begin
    {pe, iw, mr, mw, rw} = 5'b0;
    i_or_d = 1'b0;
    reg_dst = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op = 4'b0000;
    pc_src = 2'b00;
    case (cur)
      FETCH:    begin mr = 1'b1; alu_src_b = 2'b01; alu_op = 4'b0101; iw = mem_ready; pe = mem_ready; end
      DECODE:   begin alu_src_b = 2'b11; alu_op = 4'b0101; end
      EXEC_R:   begin alu_src_a = 1'b1; alu_op = r_op; end
      WB_R:     begin rw = 1'b1; reg_dst = 2'b01; end
      EXEC_I:   begin alu_src_a = 1'b1; alu_src_b = 2'b10; alu_op = i_op; end
      WB_I:     rw = 1'b1;
      MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; alu_op = 4'b0101; end
      MEM_RD:   begin mr = 1'b1; i_or_d = 1'b1; end
      WB_MEM:   begin rw = 1'b1; mem_to_reg = 2'b01; end
      MEM_WR:   begin mw = 1'b1; i_or_d = 1'b1; end
      BRANCH:   begin alu_src_a = 1'b1; alu_op = 4'b0110; pc_src = 2'b01; pe = opcode == 6'd4 ? zero : !zero; end
      JUMP:     begin pc_src = 2'b11; pe = 1'b1; end
      JAL:      begin pc_src = 2'b11; pe = 1'b1; rw = 1'b1; reg_dst = 2'b10; mem_to_reg = 2'b10; end
      JR:       begin pc_src = 2'b10; pe = 1'b1; end
      default:  ;
    endcase
  end
  // state is already FETCH during reset; only the enables need the extra gate
  assign pc_en = pe & rst_n;
  assign ir_write = iw & rst_n;
  assign mem_read = mr & rst_n;
  assign mem_write = mw & rst_n;
  assign reg_write = rw & rst_n;
  assign illegal = cur == ILLEGAL;
  assign state = cur;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random instruction stream checked cycle by cycle against a per-instruction behavioural model.
module tb_multicycle_control;
  logic clk = 0, rst_n = 0, zero = 0, mem_ready = 1;
  logic [5:0] opcode = 0, funct = 0;
  logic pc_en, ir_write, mem_read, mem_write, i_or_d, reg_write, alu_src_a, illegal;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic [3:0] alu_op, state;
  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .illegal(illegal), .state(state)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] st;
    logic pe, iw, mr, mw, iod, rw;
    logic [1:0] rd, m2r;
    logic asa;
    logic [1:0] asb;
    logic [3:0] op;
    logic [1:0] ps;
    logic ill;
  } out_t;
  int total = 0, bad = 0, ncyc = 0, len;
  out_t exp_o, act_o;
  logic exp_valid = 0;
  logic [5:0] rf [8] = '{6'd33, 6'd35, 6'd36, 6'd37, 6'd38, 6'd43, 6'd0, 6'd2};
  logic [3:0] ra [8] = '{4'b0101, 4'b0110, 4'b0001, 4'b0011, 4'b0010, 4'b1000, 4'b1010, 4'b1011};
  logic [5:0] ic [5] = '{6'd9, 6'd12, 6'd13, 6'd11, 6'd15};
  logic [3:0] ia [5] = '{4'b0101, 4'b0001, 4'b0011, 4'b1000, 4'b1100};
  logic [5:0] lops [12] = '{6'd0, 6'd9, 6'd12, 6'd13, 6'd11, 6'd15, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3};
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  always @(negedge clk) if (exp_valid) begin
    act_o = {state, pc_en, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, alu_op, pc_src, illegal};
    chk($sformatf("cycle%0d op%0d fn%0d", ncyc, opcode, funct), 32'(act_o), 32'(exp_o));
  end
  // instruction classes: 0 R, 1 I, 2 lw, 3 sw, 4 branch, 5 j, 6 jal, 7 jr, 8 illegal
  function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
    if (op == 0) begin
      if (fn == 8) return 7;
      for (int i = 0; i < 8; i++) if (fn == rf[i]) return 0;
      return 8;
    end
    for (int i = 0; i < 5; i++) if (op == ic[i]) return 1;
    if (op == 35) return 2;
    if (op == 43) return 3;
    if (op == 4 || op == 5) return 4;
    if (op == 2) return 5;
    if (op == 3) return 6;
    return 8;
  endfunction
  function automatic logic [3:0] rop(input logic [5:0] fn);
    for (int i = 0; i < 8; i++) if (fn == rf[i]) return ra[i];
    return 4'b0000;
  endfunction
  function automatic logic [3:0] iop(input logic [5:0] op);
    for (int i = 0; i < 5; i++) if (op == ic[i]) return ia[i];
    return 4'b0000;
  endfunction
  function automatic out_t base(input logic [3:0] st);
    out_t e = '0;
    e.st = st;
    return e;
  endfunction
  task automatic cyc(input out_t e, input logic rdy, input logic z);
    mem_ready = rdy;
    zero = z;
    exp_o = e;
    exp_valid = 1;
    ncyc++;
    @(posedge clk);
    #1;
  endtask
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  task automatic reset_pulse();
    exp_valid = 0;
    mem_ready = 1;
    rst_n = 0;
    #2;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);
    chk("reset_enables", 32'({pc_en, ir_write, mem_read, mem_write, reg_write}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask
  // zs: 0/1 forces the zero flag in BRANCH, 2 randomises it
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw, input int zs);
    out_t e;
    logic z;
    int c0 = ncyc;
    int k = cls(op, fn);
    opcode = op;
    funct = fn;
    e = base(0); e.mr = 1; e.asb = 2'b01; e.op = 4'b0101;
    repeat (fw) cyc(e, 0, rb());
    e.pe = 1; e.iw = 1;
    cyc(e, 1, rb());
    e = base(1); e.asb = 2'b11; e.op = 4'b0101;
    cyc(e, rb(), rb());
    if (k == 0) begin
      e = base(2); e.asa = 1; e.op = rop(fn); cyc(e, rb(), rb());
      e = base(3); e.rw = 1; e.rd = 2'b01; cyc(e, rb(), rb());
    end else if (k == 1) begin
      e = base(4); e.asa = 1; e.asb = 2'b10; e.op = iop(op); cyc(e, rb(), rb());
      e = base(5); e.rw = 1; cyc(e, rb(), rb());
    end else if (k == 2 || k == 3) begin
      e = base(6); e.asa = 1; e.asb = 2'b10; e.op = 4'b0101; cyc(e, rb(), rb());
      e = base(k == 2 ? 4'd7 : 4'd9); e.mr = k == 2; e.mw = k == 3; e.iod = 1;
      repeat (mw) cyc(e, 0, rb());
      cyc(e, 1, rb());
      if (k == 2) begin
        e = base(8); e.rw = 1; e.m2r = 2'b01; cyc(e, rb(), rb());
      end
    end else if (k == 4) begin
      z = zs == 2 ? rb() : 1'(zs);
      e = base(10); e.asa = 1; e.op = 4'b0110; e.ps = 2'b01; e.pe = op == 4 ? z : !z;
      cyc(e, rb(), z);
    end else if (k == 5) begin
      e = base(11); e.ps = 2'b11; e.pe = 1; cyc(e, rb(), rb());
    end else if (k == 6) begin
      e = base(12); e.ps = 2'b11; e.pe = 1; e.rw = 1; e.rd = 2'b10; e.m2r = 2'b10; cyc(e, rb(), rb());
    end else if (k == 7) begin
      e = base(13); e.ps = 2'b10; e.pe = 1; cyc(e, rb(), rb());
    end else begin
      e = base(14); e.ill = 1;
      repeat (10) cyc(e, rb(), rb());
      reset_pulse();
    end
    len = ncyc - c0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("por_state", 32'(state), 32'd0);
    chk("por_enables", 32'({pc_en, ir_write, mem_read, mem_write, reg_write}), 32'd0);
    chk("por_alu_op", 32'(alu_op), 32'b0101);
    rst_n = 1;
    #1;
    chk("first_fetch", 32'({mem_read, ir_write, pc_en}), 32'b111);
    run(6'd0, 6'd33, 0, 0, 2); chk("addu_len", len, 4);
    run(6'd35, 6'd0, 0, 2, 2); chk("lw_wait_len", len, 7);
    run(6'd43, 6'd0, 0, 0, 2); chk("sw_len", len, 4);
    run(6'd4, 6'd0, 0, 0, 1); chk("beq_taken_len", len, 3);
    run(6'd4, 6'd0, 0, 0, 0);
    run(6'd5, 6'd0, 0, 0, 0);
    run(6'd3, 6'd0, 0, 0, 2); chk("jal_len", len, 3);
    run(6'd0, 6'd8, 0, 0, 2); chk("jr_len", len, 3);
    run(6'd9, 6'd0, 2, 0, 2); chk("addiu_fetch_wait_len", len, 6);
    run(6'd63, 6'd0, 0, 0, 2);
    run(6'd15, 6'd0, 0, 0, 2); chk("lui_after_reset_len", len, 4);
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op, fn;
      if ($urandom_range(0, 19) == 0) begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end else begin
        op = lops[$urandom_range(0, 11)];
        fn = $urandom_range(0, 8) == 8 ? 6'd8 : rf[$urandom_range(0, 7)];
      end
      run(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), 2);
    end
    exp_valid = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
